// File: rtl/kvs_wr_burst_gen_if.sv
// Bundle for the write-burst generator: the upstream 512-bit result stream
// plus the AW, W and B channels of the AXI4 master towards global memory.
// The master modport is the generator's view; the slave modport is the view
// of whatever sits on the other side (the producer and the memory).
interface kvs_wr_burst_gen_if #(
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_M_AXI_ADDR_WIDTH = 64
);
    logic                            s_tvalid;
    logic                            s_tready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   s_tdata;

    logic                            m_axi_awvalid;
    logic                            m_axi_awready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]                      m_axi_awlen;

    logic                            m_axi_wvalid;
    logic                            m_axi_wready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                            m_axi_wlast;

    logic                            m_axi_bvalid;
    logic                            m_axi_bready;

    modport master (
        input  s_tvalid, s_tdata,
        output s_tready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_wready,
        input  m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output s_tvalid, s_tdata,
        input  s_tready,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_wready,
        output m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/kvs_wr_burst_gen.sv
// Write-burst generator: turns the per-port result stream into AXI4 write
// bursts of up to C_BURST_BEATS beats starting at a 4 KB-aligned base, keeps
// at most C_MAX_OUTSTANDING bursts unacknowledged, and pulses ctrl_done once
// every beat has been written and every burst has received its B response.
module kvs_wr_burst_gen #(
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BURST_BEATS      = 64,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          ctrl_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_beats,
    output logic                          ctrl_busy,
    output logic                          ctrl_done,
    kvs_wr_burst_gen_if.master            bus
);
    localparam int AW         = C_M_AXI_ADDR_WIDTH;
    localparam int XW         = C_XFER_SIZE_WIDTH;
    localparam int BYTES      = C_M_AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int OUT_W      = $clog2(C_MAX_OUTSTANDING) + 1;

    localparam logic [XW-1:0]    BURST_X    = XW'(C_BURST_BEATS);
    localparam logic [XW-1:0]    BURST_LAST = XW'(C_BURST_BEATS - 1);
    localparam logic [XW-1:0]    ONE_X      = XW'(1);
    localparam logic [OUT_W-1:0] MAX_OUT    = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] ONE_OUT    = OUT_W'(1);
    localparam logic [AW-1:0]    PAGE_MASK  = ~AW'(12'hFFF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_busy;
    logic              r_done;
    logic              r_bready;
    logic              r_awvalid;
    logic [AW-1:0]     r_awaddr;
    logic [7:0]        r_awlen;
    logic [AW-1:0]     r_aw_addr;      // start address of the next burst to issue
    logic [XW-1:0]     r_aw_rem;       // beats not yet covered by an accepted AW
    logic [XW-1:0]     r_aw_cnt;       // AW bursts accepted in this transfer
    logic [XW-1:0]     r_w_rem;        // W beats still to be accepted
    logic [XW-1:0]     r_w_beat;       // beat index inside the current W burst
    logic [XW-1:0]     r_w_burst;      // index of the current W burst
    logic [OUT_W-1:0]  r_outstanding;  // accepted AW bursts awaiting B

    logic              w_start;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_dec;
    logic              w_aw_issue;
    logic              w_w_enable;
    logic              w_wlast_hit;
    logic [XW-1:0]     w_aw_len;
    logic [AW-1:0]     w_aw_step;
    logic [AW-1:0]     w_base;

    assign w_start     = (r_state == ST_IDLE) && ctrl_start;
    assign w_base      = ctrl_addr_offset & PAGE_MASK;
    assign w_aw_hs     = r_awvalid && bus.m_axi_awready;
    assign w_w_hs      = bus.m_axi_wvalid && bus.m_axi_wready;
    assign w_b_dec     = bus.m_axi_bvalid && r_bready && (r_outstanding != '0);
    assign w_aw_issue  = (r_state == ST_RUN) && !r_awvalid && (r_aw_rem != '0) &&
                         (r_outstanding < MAX_OUT);
    // W may only run inside a burst whose AW has already been accepted.
    assign w_w_enable  = (r_state == ST_RUN) && (r_w_rem != '0) && (r_w_burst < r_aw_cnt);
    // Every burst is full except possibly the final one, which ends with the transfer.
    assign w_wlast_hit = (r_w_beat == BURST_LAST) || (r_w_rem == ONE_X);
    assign w_aw_step   = (AW'(r_awlen) + AW'(1)) << BYTE_SHIFT;

    assign ctrl_busy         = r_busy;
    assign ctrl_done         = r_done;
    assign bus.s_tready      = bus.m_axi_wready & w_w_enable;
    assign bus.m_axi_wvalid  = bus.s_tvalid & w_w_enable;
    assign bus.m_axi_wdata   = bus.s_tdata;
    assign bus.m_axi_wstrb   = {BYTES{1'b1}};
    assign bus.m_axi_wlast   = w_w_enable & w_wlast_hit;
    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_awaddr  = r_awaddr;
    assign bus.m_axi_awlen   = r_awlen;
    assign bus.m_axi_bready  = r_bready;

    // Length of the next AW burst: whatever is left, capped at a full burst.
    always_comb begin
        w_aw_len = r_aw_rem;
        if (r_aw_rem > BURST_X) begin
            w_aw_len = BURST_X;
        end else begin
            w_aw_len = r_aw_rem;
        end
    end

    // Control FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_start) begin
                    if (ctrl_xfer_beats == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((r_aw_rem == '0) && !r_awvalid && (r_w_rem == '0)) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_outstanding == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Busy flag, one-cycle done pulse, and B-ready that rises once out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bready <= 1'b0;
        end else begin
            r_bready <= 1'b1;
            r_done   <= (r_state == ST_DONE);
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    // AW engine: registered request held stable until accepted, then advance.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awlen   <= 8'd0;
            r_aw_addr <= '0;
            r_aw_rem  <= '0;
            r_aw_cnt  <= '0;
        end else if (w_start) begin
            r_awvalid <= 1'b0;
            r_aw_addr <= w_base;
            r_aw_rem  <= ctrl_xfer_beats;
            r_aw_cnt  <= '0;
        end else if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_addr <= r_aw_addr + w_aw_step;
            r_aw_rem  <= r_aw_rem - (XW'(r_awlen) + ONE_X);
            r_aw_cnt  <= r_aw_cnt + ONE_X;
        end else if (w_aw_issue) begin
            r_awvalid <= 1'b1;
            r_awaddr  <= r_aw_addr;
            r_awlen   <= 8'(w_aw_len - ONE_X);
        end
    end

    // W engine: count beats within the burst and bursts within the transfer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_w_rem   <= '0;
            r_w_beat  <= '0;
            r_w_burst <= '0;
        end else if (w_start) begin
            r_w_rem   <= ctrl_xfer_beats;
            r_w_beat  <= '0;
            r_w_burst <= '0;
        end else if (w_w_hs) begin
            r_w_rem <= r_w_rem - ONE_X;
            if (w_wlast_hit) begin
                r_w_beat  <= '0;
                r_w_burst <= r_w_burst + ONE_X;
            end else begin
                r_w_beat  <= r_w_beat + ONE_X;
            end
        end
    end

    // Outstanding-burst window: up on AW accept, down on B, unchanged on both.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_outstanding <= '0;
        end else if (w_start) begin
            r_outstanding <= '0;
        end else begin
            case ({w_aw_hs, w_b_dec})
                2'b10:   r_outstanding <= r_outstanding + ONE_OUT;
                2'b01:   r_outstanding <= r_outstanding - ONE_OUT;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_kvs_wr_burst_gen.sv
// Directed bench for kvs_wr_burst_gen: a background environment plays the
// producer and the memory, logging AW requests, W beats and WLAST positions;
// each test task starts a transfer and checks the logs against hand values.
`timescale 1ns/1ps
module tb_kvs_wr_burst_gen;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int XW = 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          ctrl_start;
    logic [AW-1:0] ctrl_addr_offset;
    logic [XW-1:0] ctrl_xfer_beats;
    logic          ctrl_busy;
    logic          ctrl_done;

    int n_vec = 0;
    int n_err = 0;

    bit stall_rand = 1'b0;
    bit b_hold     = 1'b0;

    logic [31:0] src_cnt = 32'd0;
    logic [63:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_data_q[$];
    int          wlast_q[$];
    int          b_timer[$];
    int          xfer_beat = 0;
    int          done_cnt = 0;
    int          aw_unstable = 0;
    int          tready_hi_cnt = 0;

    always #5 aclk = ~aclk;

    kvs_wr_burst_gen_if #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) bus ();

    kvs_wr_burst_gen #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_XFER_SIZE_WIDTH (XW),
        .C_BURST_BEATS     (64),
        .C_MAX_OUTSTANDING (4)
    ) u_dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .ctrl_start      (ctrl_start),
        .ctrl_addr_offset(ctrl_addr_offset),
        .ctrl_xfer_beats (ctrl_xfer_beats),
        .ctrl_busy       (ctrl_busy),
        .ctrl_done       (ctrl_done),
        .bus             (bus)
    );

    // Producer + memory model: sample at the falling edge, drive after the rising edge.
    initial begin : env
        bit aw_f, w_f, s_f, b_f, prev_wait;
        logic [63:0] prev_addr;
        logic [7:0]  prev_len;
        prev_wait = 1'b0; prev_addr = 64'd0; prev_len = 8'd0;
        bus.s_tvalid = 1'b0; bus.s_tdata = '0;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
        forever begin
            @(negedge aclk);
            aw_f = bus.m_axi_awvalid && bus.m_axi_awready;
            w_f  = bus.m_axi_wvalid && bus.m_axi_wready;
            s_f  = bus.s_tvalid && bus.s_tready;
            b_f  = bus.m_axi_bvalid && bus.m_axi_bready;
            if (!aresetn || (ctrl_start && !ctrl_busy)) xfer_beat = 0;
            if (bus.s_tready) tready_hi_cnt++;
            if (ctrl_done) done_cnt++;
            if (prev_wait && aresetn && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== prev_addr ||
                                         bus.m_axi_awlen !== prev_len)) aw_unstable++;
            prev_wait = aresetn && bus.m_axi_awvalid && !bus.m_axi_awready;
            prev_addr = bus.m_axi_awaddr;
            prev_len  = bus.m_axi_awlen;
            if (aw_f) begin
                aw_addr_q.push_back(bus.m_axi_awaddr);
                aw_len_q.push_back(bus.m_axi_awlen);
            end
            if (w_f) begin
                xfer_beat++;
                w_data_q.push_back(bus.m_axi_wdata[31:0]);
                if (bus.m_axi_wlast) begin
                    wlast_q.push_back(xfer_beat);
                    b_timer.push_back(2);
                end
            end
            @(posedge aclk);
            #1;
            if (s_f) src_cnt = src_cnt + 32'd1;
            if (b_f && b_timer.size() > 0) void'(b_timer.pop_front());
            foreach (b_timer[i]) if (b_timer[i] > 0) b_timer[i] = b_timer[i] - 1;
            if (!aresetn) b_timer.delete();
            bus.s_tdata       = {16{src_cnt}};
            bus.s_tvalid      = stall_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.m_axi_awready = stall_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
            bus.m_axi_wready  = stall_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.m_axi_bvalid  = !b_hold && (b_timer.size() > 0) && (b_timer[0] == 0);
        end
    end

    task automatic start_xfer(input logic [63:0] addr, input logic [31:0] beats);
        @(posedge aclk); #1;
        ctrl_addr_offset = addr;
        ctrl_xfer_beats  = beats;
        ctrl_start       = 1'b1;
        @(posedge aclk); #1;
        ctrl_start       = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk); #1;
            if (done_cnt != d0) break;
        end
        repeat (4) @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        n_vec++;
        if ({ctrl_busy, ctrl_done, bus.s_tready, bus.m_axi_awvalid, bus.m_axi_wvalid,
             bus.m_axi_wlast, bus.m_axi_bready} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy/done/trdy/awv/wv/wlast/brdy=%b%b%b%b%b%b%b want 0000000",
                     ctrl_busy, ctrl_done, bus.s_tready, bus.m_axi_awvalid, bus.m_axi_wvalid,
                     bus.m_axi_wlast, bus.m_axi_bready);
        end
        n_vec++;
        if ({bus.m_axi_awaddr, bus.m_axi_awlen} !== 72'd0) begin
            n_err++;
            $display("FAIL reset_aw: got addr=%h len=%0d want 0/0", bus.m_axi_awaddr, bus.m_axi_awlen);
        end
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        n_vec++;
        if (bus.m_axi_bready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_bready: got %b want 1", bus.m_axi_bready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] exp_a[2] = '{64'h1000_0000, 64'h1000_1000};
        int a0 = aw_addr_q.size(), w0 = w_data_q.size(), l0 = wlast_q.size(), d0 = done_cnt, bad = -1;
        logic [31:0] base = src_cnt;
        start_xfer(64'h1000_0000, 32'd128);
        n_vec++;
        if (bus.m_axi_wstrb !== {64{1'b1}}) begin
            n_err++; $display("FAIL basic_wstrb: got %h want all ones", bus.m_axi_wstrb);
        end
        wait_done(d0, 2000);
        n_vec++;
        if (aw_addr_q.size() - a0 !== 2) begin
            n_err++; $display("FAIL basic_awcnt: got %0d want 2", aw_addr_q.size() - a0);
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (aw_addr_q[a0+i] !== exp_a[i] || aw_len_q[a0+i] !== 8'd63) begin
                n_err++; $display("FAIL basic_aw%0d: got %h/%0d want %h/63", i, aw_addr_q[a0+i], aw_len_q[a0+i], exp_a[i]);
            end
        end
        n_vec++;
        if (w_data_q.size() - w0 !== 128 || wlast_q.size() - l0 !== 2 ||
            wlast_q[l0] !== 64 || wlast_q[l0+1] !== 128) begin
            n_err++; $display("FAIL basic_w: got beats=%0d lasts=%0d want 128 beats, wlast at 64,128",
                              w_data_q.size() - w0, wlast_q.size() - l0);
        end
        for (int i = 0; i < 128; i++) if (bad < 0 && w_data_q[w0+i] !== base + 32'(i)) bad = i;
        n_vec++;
        if (bad != -1) begin
            n_err++; $display("FAIL basic_data: got first bad beat %0d want -1", bad);
        end
        n_vec++;
        if (done_cnt - d0 !== 1 || ctrl_busy !== 1'b0) begin
            n_err++; $display("FAIL basic_done: got pulses=%0d busy=%b want 1/0", done_cnt - d0, ctrl_busy);
        end
    endtask

    task automatic test_unaligned();
        int a0 = aw_addr_q.size(), l0 = wlast_q.size(), d0 = done_cnt;
        start_xfer(64'h2000_0ABC, 32'd70);
        wait_done(d0, 2000);
        n_vec++;
        if (aw_addr_q.size() - a0 !== 2 || aw_addr_q[a0] !== 64'h2000_0000 || aw_len_q[a0] !== 8'd63 ||
            aw_addr_q[a0+1] !== 64'h2000_1000 || aw_len_q[a0+1] !== 8'd5) begin
            n_err++; $display("FAIL unal_aw: got %h/%0d %h/%0d want 20000000/63 20001000/5",
                              aw_addr_q[a0], aw_len_q[a0], aw_addr_q[a0+1], aw_len_q[a0+1]);
        end
        n_vec++;
        if (wlast_q.size() - l0 !== 2 || wlast_q[l0] !== 64 || wlast_q[l0+1] !== 70) begin
            n_err++; $display("FAIL unal_wlast: got %0d,%0d want 64,70", wlast_q[l0], wlast_q[l0+1]);
        end
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL unal_done: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_zero();
        int a0 = aw_addr_q.size(), w0 = w_data_q.size(), d0 = done_cnt;
        start_xfer(64'h7000_0000, 32'd0);
        @(negedge aclk);
        n_vec++;
        if ({ctrl_done, ctrl_busy} !== 2'b01) begin
            n_err++; $display("FAIL zero_c1: got done/busy=%b%b want 01", ctrl_done, ctrl_busy);
        end
        @(negedge aclk);
        n_vec++;
        if ({ctrl_done, ctrl_busy} !== 2'b10) begin
            n_err++; $display("FAIL zero_c2: got done/busy=%b%b want 10", ctrl_done, ctrl_busy);
        end
        @(negedge aclk);
        n_vec++;
        if (ctrl_done !== 1'b0) begin
            n_err++; $display("FAIL zero_c3: got done=%b want 0", ctrl_done);
        end
        repeat (5) @(negedge aclk);
        n_vec++;
        if (aw_addr_q.size() - a0 !== 0 || w_data_q.size() - w0 !== 0 || done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL zero_act: got aw=%0d w=%0d done=%0d want 0/0/1",
                              aw_addr_q.size() - a0, w_data_q.size() - w0, done_cnt - d0);
        end
    endtask

    task automatic test_outstanding();
        int a0 = aw_addr_q.size(), w0 = w_data_q.size(), l0 = wlast_q.size(), d0 = done_cnt, t0, bad = -1;
        b_hold = 1'b1;
        start_xfer(64'h3000_0000, 32'd640);
        for (int i = 0; i < 1000 && (w_data_q.size() - w0) < 256; i++) @(negedge aclk);
        repeat (20) @(negedge aclk);
        n_vec++;
        if (aw_addr_q.size() - a0 !== 4 || bus.m_axi_awvalid !== 1'b0) begin
            n_err++; $display("FAIL out_aw: got aw=%0d awvalid=%b want 4/0", aw_addr_q.size() - a0, bus.m_axi_awvalid);
        end
        t0 = tready_hi_cnt;
        repeat (30) @(negedge aclk);
        n_vec++;
        if (w_data_q.size() - w0 !== 256 || tready_hi_cnt - t0 !== 0) begin
            n_err++; $display("FAIL out_stall: got beats=%0d tready_cycles=%0d want 256/0",
                              w_data_q.size() - w0, tready_hi_cnt - t0);
        end
        b_hold = 1'b0;
        wait_done(d0, 4000);
        for (int i = 0; i < 10; i++)
            if (bad < 0 && (aw_addr_q[a0+i] !== 64'h3000_0000 + 64'(i) * 64'h1000 || aw_len_q[a0+i] !== 8'd63)) bad = i;
        n_vec++;
        if (aw_addr_q.size() - a0 !== 10 || bad != -1) begin
            n_err++; $display("FAIL out_bursts: got count=%0d first bad=%0d want 10/-1", aw_addr_q.size() - a0, bad);
        end
        n_vec++;
        if (w_data_q.size() - w0 !== 640 || wlast_q.size() - l0 !== 10 || wlast_q[l0+9] !== 640) begin
            n_err++; $display("FAIL out_w: got beats=%0d lasts=%0d want 640/10", w_data_q.size() - w0, wlast_q.size() - l0);
        end
        n_vec++;
        if (done_cnt - d0 !== 1 || ctrl_busy !== 1'b0) begin
            n_err++; $display("FAIL out_done: got %0d/%b want 1/0", done_cnt - d0, ctrl_busy);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp_a[4] = '{64'h4000_5000, 64'h4000_6000, 64'h4000_7000, 64'h4000_8000};
        logic [7:0]  exp_l[4] = '{8'd63, 8'd63, 8'd63, 8'd7};
        int          exp_w[4] = '{64, 128, 192, 200};
        int a0 = aw_addr_q.size(), w0 = w_data_q.size(), l0 = wlast_q.size(), d0 = done_cnt;
        int u0 = aw_unstable, bad = -1;
        logic [31:0] base = src_cnt;
        stall_rand = 1'b1;
        start_xfer(64'h4000_5000, 32'd200);
        wait_done(d0, 4000);
        stall_rand = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (aw_addr_q[a0+i] !== exp_a[i] || aw_len_q[a0+i] !== exp_l[i] || wlast_q[l0+i] !== exp_w[i]) begin
                n_err++; $display("FAIL stall_burst%0d: got %h/%0d wlast@%0d want %h/%0d wlast@%0d", i,
                                  aw_addr_q[a0+i], aw_len_q[a0+i], wlast_q[l0+i], exp_a[i], exp_l[i], exp_w[i]);
            end
        end
        for (int i = 0; i < 200; i++) if (bad < 0 && w_data_q[w0+i] !== base + 32'(i)) bad = i;
        n_vec++;
        if (w_data_q.size() - w0 !== 200 || bad != -1) begin
            n_err++; $display("FAIL stall_data: got beats=%0d first bad=%0d want 200/-1", w_data_q.size() - w0, bad);
        end
        n_vec++;
        if (aw_unstable - u0 !== 0 || aw_addr_q.size() - a0 !== 4) begin
            n_err++; $display("FAIL stall_awhold: got changes=%0d bursts=%0d want 0/4", aw_unstable - u0, aw_addr_q.size() - a0);
        end
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL stall_done: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_midreset();
        int w0 = w_data_q.size(), d0 = done_cnt, a0, l0;
        logic [31:0] base;
        start_xfer(64'h5000_0000, 32'd128);
        for (int i = 0; i < 500 && (w_data_q.size() - w0) < 30; i++) begin @(negedge aclk); #1; end
        #1 aresetn = 1'b0;
        #1;
        n_vec++;
        if ({ctrl_busy, ctrl_done, bus.s_tready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast,
             bus.m_axi_bready} !== 7'b0 || {bus.m_axi_awaddr, bus.m_axi_awlen} !== 72'd0) begin
            n_err++; $display("FAIL mrst_out: got busy=%b trdy=%b awv=%b wv=%b brdy=%b awaddr=%h want all 0",
                              ctrl_busy, bus.s_tready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_awaddr);
        end
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        n_vec++;
        if (done_cnt - d0 !== 0 || ctrl_busy !== 1'b0) begin
            n_err++; $display("FAIL mrst_nodone: got pulses=%0d busy=%b want 0/0", done_cnt - d0, ctrl_busy);
        end
        a0 = aw_addr_q.size(); l0 = wlast_q.size(); w0 = w_data_q.size(); d0 = done_cnt; base = src_cnt;
        start_xfer(64'h6000_1234, 32'd64);
        wait_done(d0, 2000);
        n_vec++;
        if (aw_addr_q.size() - a0 !== 1 || aw_addr_q[a0] !== 64'h6000_1000 || aw_len_q[a0] !== 8'd63) begin
            n_err++; $display("FAIL mrst_aw: got n=%0d %h/%0d want 1 60001000/63", aw_addr_q.size() - a0, aw_addr_q[a0], aw_len_q[a0]);
        end
        n_vec++;
        if (wlast_q.size() - l0 !== 1 || wlast_q[l0] !== 64 || w_data_q[w0] !== base || w_data_q[w0+63] !== base + 32'd63) begin
            n_err++; $display("FAIL mrst_w: got lasts=%0d first=%h last=%h want 1 %h %h",
                              wlast_q.size() - l0, w_data_q[w0], w_data_q[w0+63], base, base + 32'd63);
        end
        n_vec++;
        if (done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL mrst_done: got %0d want 1", done_cnt - d0);
        end
    endtask

    // Test sequence.
    initial begin
        aresetn          = 1'b0;
        ctrl_start       = 1'b0;
        ctrl_addr_offset = 64'd0;
        ctrl_xfer_beats  = 32'd0;
        test_reset();
        test_basic();
        test_unaligned();
        test_zero();
        test_outstanding();
        test_stall();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
